// File: rtl/udp_perf_mon_rx.sv
// Receive-side throughput and integrity monitor for the UDP loopback perf setup.
// Sinks the 512-bit stream delivered toward the host, checks every counted beat
// against the generator's pattern (each 32-bit lane = running beat count) and
// keeps cycle/beat/packet/error counters for ILA probing.
module udp_perf_mon_rx (
  input  logic         udp_clk,
  input  logic         udp_reset,
  input  logic         start,
  input  logic [31:0]  pkt_size,
  input  logic [31:0]  pkt_num,
  input  logic         udp_rx_axis_tvalid,
  input  logic [511:0] udp_rx_axis_tdata,
  input  logic [63:0]  udp_rx_axis_tkeep,
  input  logic         udp_rx_axis_tlast,
  input  logic         udp_rx_axis_tuser,
  output logic         udp_rx_axis_tready,
  output logic         recv_pkt_enable,
  output logic         is_recv_first_frame,
  output logic [31:0]  perf_cycle_counter_rx,
  output logic [31:0]  total_beat_counter_rx,
  output logic [31:0]  total_pkt_counter_rx,
  output logic [31:0]  err_beat_counter_rx,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t      state;
  // Packet size is held as S-1: its upper bits are the index of the last beat
  // (ceil(S/64)-1) and its low six bits are the last enabled byte of that beat.
  logic [31:0] size_m1;
  logic [31:0] pkt_target;
  logic [25:0] beat_idx;

  logic        handshake;
  logic [25:0] last_idx;
  logic        is_last_idx;
  logic [63:0] exp_keep;
  logic        data_bad;
  logic        beat_err;
  logic [25:0] beat_idx_nxt;

  // The monitor never back-pressures; it only refuses beats while in reset.
  assign udp_rx_axis_tready = ~udp_reset;
  assign handshake          = udp_rx_axis_tvalid & udp_rx_axis_tready;
  assign last_idx           = size_m1[31:6];
  assign is_last_idx        = (beat_idx == last_idx);

  // Expected keep, pattern comparison on enabled bytes, and in-packet index advance.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    exp_keep = '1;
    data_bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (is_last_idx && (6'(i) > size_m1[5:0])) exp_keep[i] = 1'b0;
      if (exp_keep[i] &&
          (udp_rx_axis_tdata[8*i +: 8] != total_beat_counter_rx[8*(i%4) +: 8]))
        data_bad = 1'b1;
    end
    beat_err = data_bad
             | (udp_rx_axis_tkeep != exp_keep)
             | (udp_rx_axis_tlast != is_last_idx)
             | udp_rx_axis_tuser;
    // Wrapping at the expected last beat resynchronises to a sender that omitted tlast.
    beat_idx_nxt = (udp_rx_axis_tlast || is_last_idx) ? '0 : beat_idx + 26'd1;
  end

  // Control FSM with registered status flags and the four counters.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge udp_clk) begin
    if (udp_reset) begin
      state                 <= IDLE;
      size_m1               <= '0;
      pkt_target            <= '0;
      beat_idx              <= '0;
      perf_cycle_counter_rx <= '0;
      total_beat_counter_rx <= '0;
      total_pkt_counter_rx  <= '0;
      err_beat_counter_rx   <= '0;
      recv_pkt_enable       <= 1'b0;
      is_recv_first_frame   <= 1'b0;
      done                  <= 1'b0;
    end else if (start) begin
      // start wins over a coincident beat: the beat is drained, not counted.
      size_m1               <= (pkt_size == 32'd0) ? 32'd0 : pkt_size - 32'd1;
      pkt_target            <= pkt_num;
      beat_idx              <= '0;
      perf_cycle_counter_rx <= '0;
      total_beat_counter_rx <= '0;
      total_pkt_counter_rx  <= '0;
      err_beat_counter_rx   <= '0;
      if (pkt_num == 32'd0) begin
        state               <= DONE;
        recv_pkt_enable     <= 1'b0;
        is_recv_first_frame <= 1'b0;
        done                <= 1'b1;
      end else begin
        state               <= ARMED;
        recv_pkt_enable     <= 1'b1;
        is_recv_first_frame <= 1'b1;
        done                <= 1'b0;
      end
    end else begin
      case (state)
        ARMED, RUN: begin
          if (state == RUN) perf_cycle_counter_rx <= perf_cycle_counter_rx + 32'd1;
          if (handshake) begin
            // The first counted beat opens the perf window at 1 (overrides the increment).
            if (state == ARMED) perf_cycle_counter_rx <= 32'd1;
            total_beat_counter_rx <= total_beat_counter_rx + 32'd1;
            if (udp_rx_axis_tlast) total_pkt_counter_rx <= total_pkt_counter_rx + 32'd1;
            if (beat_err) err_beat_counter_rx <= err_beat_counter_rx + 32'd1;
            beat_idx            <= beat_idx_nxt;
            state               <= RUN;
            is_recv_first_frame <= 1'b0;
            if (udp_rx_axis_tlast && (total_pkt_counter_rx + 32'd1 == pkt_target)) begin
              state           <= DONE;
              recv_pkt_enable <= 1'b0;
              done            <= 1'b1;
            end
          end
        end
        default: ; // IDLE and DONE drain the stream and hold all counters
      endcase
    end
  end

endmodule

// File: doc/udp_perf_mon_rx.md
# udp_perf_mon_rx

Receive-side throughput and integrity monitor for the UDP/IP/ARP/Ethernet loopback perf setup. It sinks the 512-bit AXI-Stream that the UDP stack delivers toward the host and checks every beat against the deterministic pattern the transmit-side generator emits. It also counts cycles, beats, packets and erroneous beats for ILA probing. It sits between the UDP stack's xdma_rx stream and the perf counter ILA, in the udp_clk domain.

## Interface
- No parameters. Data width is fixed at 512 bits; keep width is fixed at 64 bits.
- udp_clk  in  1  clock
- udp_reset  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  single-cycle pulse; latches config, clears counters, arms monitor
- pkt_size  in  32  bytes per packet, sampled on start
- pkt_num  in  32  packets expected, sampled on start
- udp_rx_axis_tvalid  in  1  beat valid
- udp_rx_axis_tdata  in  512  beat data
- udp_rx_axis_tkeep  in  64  byte enables, bit i covers tdata[8i+7:8i]
- udp_rx_axis_tlast  in  1  last beat of packet
- udp_rx_axis_tuser  in  1  error flag from stack
- udp_rx_axis_tready  out  1  sink ready
- recv_pkt_enable  out  1  high in ARMED or RUN
- is_recv_first_frame  out  1  high in ARMED
- perf_cycle_counter_rx  out  32  cycles from first to last counted beat, inclusive
- total_beat_counter_rx  out  32  beats counted
- total_pkt_counter_rx  out  32  tlast beats counted
- err_beat_counter_rx  out  32  beats with at least one error
- done  out  1  high in DONE

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset enters IDLE.
- Any state, start=1:
  - Latch S = max(pkt_size, 1) and N = pkt_num.
  - Clear all four counters and the in-packet beat index b.
  - Go to ARMED, or go to DONE if N == 0.
- ARMED: the first handshake (tvalid & tready) is counted, perf counter is set to 1, and the state goes to RUN. If that beat completes packet N, the state goes straight to DONE.
- RUN: perf counter increments every cycle. Every handshake is counted. When the counted tlast beat makes total_pkt == N, the state goes to DONE. That final cycle is included in the perf count.
- DONE and IDLE: the stream is still drained, but beats are not counted. All counters hold.
- Derived values:
  - Beats per packet: B = ceil(S/64).
  - Last-beat bytes: L = S − 64·(B−1).
  - Expected tkeep: all ones for b < B−1; low L bits set for b == B−1.
- Expected data: every 32-bit lane j (tdata[32j+31:32j]) equals the pre-increment value of total_beat_counter_rx. Only lanes whose 4 expected-keep bits are all set are compared. The last lane of a partial beat is compared bytewise on the enabled bytes.
- A counted beat is an error if any of the following holds; each error beat increments err_beat_counter_rx once:
  - data mismatch;
  - tkeep differs from expected;
  - tlast differs from (b == B−1);
  - tuser == 1.
- b advances as follows:
  - it returns to 0 on any counted tlast;
  - it also returns to 0 if b == B−1 while tlast == 0, so the monitor resynchronises to the sender rather than running away;
  - otherwise it increments.
- total_pkt_counter_rx increments on every counted tlast beat, including error beats.
- All counters wrap modulo 2^32; there is no saturation.

## Timing
- udp_rx_axis_tready = ~udp_reset. It is otherwise always 1, so the monitor never back-pressures the stack.
- All outputs are registered. A counter reflects a handshake on the cycle after it.
- recv_pkt_enable, is_recv_first_frame and done change on the cycle after their transition condition.
- Reset values: every counter is 0; recv_pkt_enable, is_recv_first_frame and done are 0; udp_rx_axis_tready is 0 during reset.
- start in the same cycle as a handshake: start wins. The beat is drained but not counted or checked.
- start during RUN: an immediate restart, with counters cleared on the next cycle.
- udp_reset asserted mid-packet: return to IDLE next cycle and clear everything; the partial packet is forgotten.
- Config inputs are ignored except in the start cycle.

## Test plan
- S=128, N=4, pattern-correct back-to-back beats after start → at done: beats=8, pkts=4, err=0, perf=8.
- S=100, N=2, with one idle cycle between packets → tkeep on beat 1 = 0x0000000FFFFFFFFF; beats=4, pkts=2, err=0, perf=5.
- S=64, N=3, with lane 5 of beat 1 corrupted and tuser=1 on beat 2 → err=2, pkts=3, beats=3.
- S=192, N=1, with tlast early on beat 1 and then 1 more beat with tlast → err≥1, pkts increments per tlast, and done occurs after the first tlast with pkts=1.
- Start pulse coincident with a valid beat, then N=0 start → first beat uncounted (beats=0), done=1 the next cycle with counters at 0.
- Reset asserted mid-run with counters nonzero → next cycle all outputs 0, tready 0 during reset and 1 after it; beats arriving in IDLE are not counted.
